// File: rtl/aes_loader_pkg.sv
// Shared sizes, slot index type and FSM state encoding for the AES word loader.
package aes_loader_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int SLOT_W          = $clog2(WORDS_PER_BLOCK);
    localparam int HOLD_W          = 8;
    localparam int WAIT_W          = 16;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Collects four 32-bit words, most-significant first, into one 128-bit block
// and tracks which slot is next plus whether the block is complete.
module aes_word_assembler
    import aes_loader_pkg::*;
#(
    parameter bit RESTART_ON_FULL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               clr,
    input  logic [WORD_W-1:0]  word,
    output logic [BLOCK_W-1:0] block,
    output logic               full
);

    slot_t cnt;
    slot_t wr_slot;

    // NOTE: always_comb assigns its output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_slot = cnt;
        if (RESTART_ON_FULL && full) begin
            wr_slot = '0;
        end
    end

    // NOTE: the block register is reset as well, because the AES core must see all-zero key/data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block <= '0;
            cnt   <= '0;
            full  <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (wr_en) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                if (wr_slot == slot_t'(k)) begin
                    block[BLOCK_W-1-WORD_W*k -: WORD_W] <= word;
                end
            end
            cnt  <= wr_slot + 1'b1;
            // Slot 0 starts a fresh frame (clears full); slot 3 completes it.
            full <= (wr_slot == LAST_SLOT);
        end
    end

endmodule

// File: rtl/aes_word_loader.sv
// Streams 32-bit key/plaintext words into 128-bit AES_top inputs and sequences AES_en.
// Optional: define AES_LOADER_TIMEOUT_EN to bound the wait for AES_data_out_valid.
module aes_word_loader
    import aes_loader_pkg::*;
#(
    parameter int EN_HOLD = 51,
    parameter int TIMEOUT = 1024
) (
    input  logic               AES_clk,
    input  logic               AES_rst,
    input  logic [WORD_W-1:0]  s_word,
    input  logic               s_key_sel,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               AES_en,
    output logic [BLOCK_W-1:0] AES_data_in,
    output logic [BLOCK_W-1:0] AES_key_in,
    input  logic               AES_data_out_valid,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    if (EN_HOLD < 1 || EN_HOLD > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_range
        $error("aes_word_loader: EN_HOLD or TIMEOUT out of range");
    end

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EN_HOLD - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              key_loaded;
    logic              data_full;
    logic              launch_pending;
    logic              accept;

    assign launch_pending = data_full & key_loaded;
    assign s_ready        = ~AES_rst & (state == IDLE) & ~launch_pending;
    assign accept         = s_valid & s_ready;
    assign busy           = (state != IDLE);

    aes_word_assembler #(.RESTART_ON_FULL(1'b0)) u_key (
        .clk   (AES_clk),
        .rst   (AES_rst),
        .wr_en (accept & s_key_sel),
        .clr   (1'b0),
        .word  (s_word),
        .block (AES_key_in),
        .full  (key_loaded)
    );

    // The data frame is released on completion; the key stays loaded for reuse.
    aes_word_assembler #(.RESTART_ON_FULL(1'b1)) u_data (
        .clk   (AES_clk),
        .rst   (AES_rst),
        .wr_en (accept & ~s_key_sel),
        .clr   (state == DONE),
        .word  (s_word),
        .block (AES_data_in),
        .full  (data_full)
    );

`ifdef AES_LOADER_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            AES_en   <= 1'b0;
            done     <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
            if (accept && !s_key_sel) begin
                timeout_err <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (launch_pending) begin
                        state    <= RUN;
                        AES_en   <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                RUN: begin
                    // An early completion cuts the enable window short and skips WAIT.
                    if (AES_data_out_valid) begin
                        state  <= DONE;
                        AES_en <= 1'b0;
                        done   <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state  <= WAIT;
                        AES_en <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (AES_data_out_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
`ifdef AES_LOADER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: directed scenarios plus randomized blocks
// checked against a word-list model of key/data framing and block timing.
module tb_aes_word_loader;

    localparam int EN_HOLD = 51;
    localparam int TMO     = 16;

    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b0;
    logic [31:0]  s_word = '0;
    logic         s_key_sel = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         AES_data_out_valid = 1'b0;
    logic         busy;
    logic         done;
    logic         timeout_err;

    always #5 AES_clk = ~AES_clk;

    aes_word_loader #(.EN_HOLD(EN_HOLD), .TIMEOUT(TMO)) dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .s_word             (s_word),
        .s_key_sel          (s_key_sel),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out_valid (AES_data_out_valid),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: key words counted since reset, current data frame as a word list,
    // and the last value written to each 32-bit slot.
    logic [31:0] m_key  [4];
    logic [31:0] m_dreg [4];
    logic [31:0] m_dq   [$];
    int          m_nkey;

    function automatic bit m_key_loaded();
        return (m_nkey > 0) && (m_nkey % 4 == 0);
    endfunction

    function automatic bit m_launch();
        return m_key_loaded() && (m_dq.size() == 4);
    endfunction

    function automatic logic [127:0] m_key_blk();
        return {m_key[0], m_key[1], m_key[2], m_key[3]};
    endfunction

    function automatic logic [127:0] m_data_blk();
        return {m_dreg[0], m_dreg[1], m_dreg[2], m_dreg[3]};
    endfunction

    task automatic model_reset();
        m_nkey = 0;
        m_dq.delete();
        for (int k = 0; k < 4; k++) begin
            m_key[k]  = '0;
            m_dreg[k] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge AES_clk);
        AES_rst = 1'b1;
        s_valid = 1'b0;
        AES_data_out_valid = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_en", AES_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key", AES_key_in, 0);
        check("rst_data", AES_data_in, 0);
        check("rst_terr", timeout_err, 0);
        model_reset();
        @(negedge AES_clk);
        AES_rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_ready, 1);
        @(negedge AES_clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send_word(input logic ks, input logic [31:0] w);
        int t = 0;
        while (!s_ready && t < 100) begin
            @(negedge AES_clk);
            t++;
        end
        if (!s_ready) begin
            check("send_ready_timeout", s_ready, 1);
            return;
        end
        s_valid   = 1'b1;
        s_key_sel = ks;
        s_word    = w;
        @(negedge AES_clk);
        s_valid = 1'b0;
        if (ks) begin
            m_key[m_nkey % 4] = w;
            m_nkey++;
        end else begin
            if (m_dq.size() == 4) m_dq.delete();
            m_dreg[m_dq.size()] = w;
            m_dq.push_back(w);
        end
    endtask

    task automatic check_launch(input string tag);
        check({tag, "_pending_model"}, m_launch(), 1);
        check({tag, "_pre_en"}, AES_en, 0);
        check({tag, "_pre_ready"}, s_ready, 0);
        check({tag, "_key"}, AES_key_in, m_key_blk());
        check({tag, "_data"}, AES_data_in, m_data_blk());
    endtask

    // valid_at: cycle index (0 = first AES_en-high cycle) on which completion is returned.
    task automatic run_block(input string tag, input int valid_at);
        int en_cnt   = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int exp_en;
        check_launch(tag);
        for (int i = 0; i < valid_at + 3; i++) begin
            @(negedge AES_clk);
            if (i == 0) begin
                check({tag, "_en_rise"}, AES_en, 1);
                check({tag, "_busy"}, busy, 1);
            end
            if (AES_en === 1'b1) en_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            AES_data_out_valid = (i == valid_at);
        end
        exp_en = (valid_at + 1 < EN_HOLD) ? valid_at + 1 : EN_HOLD;
        check({tag, "_en_cycles"}, en_cnt, exp_en);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, valid_at + 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ready"}, s_ready, 1);
        m_dq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          en_cnt;
        int          done_cnt;
        int          done_at;
        model_reset();
        do_reset();

        // 1. Basic block
        send_word(1'b1, 32'haa2bdb40);
        send_word(1'b1, 32'hbff6a5e8);
        send_word(1'b1, 32'hcaa9ba3e);
        send_word(1'b1, 32'hbc1e2acc);
        send_word(1'b0, 32'h0000001c);
        send_word(1'b0, 32'h0);
        send_word(1'b0, 32'h0);
        send_word(1'b0, 32'h0);
        check("t1_key_const", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        check("t1_data_const", AES_data_in, 128'h0000001c_00000000_00000000_00000000);
        run_block("t1", EN_HOLD + 10);

        // 2. Key reuse: data only
        send_word(1'b0, 32'ha6f2daeb);
        send_word(1'b0, 32'h140fa720);
        send_word(1'b0, 32'h529e75d5);
        send_word(1'b0, 32'h21cbc681);
        run_block("t2", EN_HOLD + 3);

        // Completion strobe in IDLE is ignored
        AES_data_out_valid = 1'b1;
        @(negedge AES_clk);
        AES_data_out_valid = 1'b0;
        @(negedge AES_clk);
        check("idle_valid_busy", busy, 0);
        check("idle_valid_done", done, 0);

        // 4. Early valid on RUN cycle 20
        for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
        run_block("t4", 20);

        // Randomized blocks, optional key reload, completion anywhere in RUN or WAIT
        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) send_word(1'b1, $urandom);
            end
            for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
            run_block("rnd", int'($urandom_range(0, EN_HOLD + 15)));
        end

        // 5. No completion returned
        for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
        check_launch("t5");
        done_cnt = 0;
        done_at  = -1;
`ifdef AES_LOADER_TIMEOUT_EN
        for (int i = 0; i < EN_HOLD + TMO + 4; i++) begin
            @(negedge AES_clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
        end
        check("t5_done_cnt", done_cnt, 1);
        check("t5_done_at", done_at, EN_HOLD + TMO);
        check("t5_terr_set", timeout_err, 1);
        check("t5_busy", busy, 0);
        m_dq.delete();
        send_word(1'b1, $urandom);
        check("t5_terr_sticky", timeout_err, 1);
        send_word(1'b0, $urandom);
        check("t5_terr_clear", timeout_err, 0);
`else
        for (int i = 0; i < 300; i++) begin
            @(negedge AES_clk);
            if (done === 1'b1) done_cnt++;
        end
        check("t5_busy_stuck", busy, 1);
        check("t5_no_done", done_cnt, 0);
        check("t5_terr_zero", timeout_err, 0);
`endif

        // 3. Data before key
        do_reset();
        for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
        repeat (3) @(negedge AES_clk);
        check("t3_ready_nokey", s_ready, 1);
        check("t3_en_nokey", AES_en, 0);
        check("t3_model_nolaunch", m_launch(), 0);
        send_word(1'b0, 32'hf301a68a);
        check("t3_slot0", AES_data_in[127:96], 32'hf301a68a);
        check("t3_restart_data", AES_data_in, m_data_blk());
        for (int k = 0; k < 4; k++) send_word(1'b1, $urandom);
        check("t3_en_no_full", AES_en, 0);
        for (int k = 0; k < 3; k++) send_word(1'b0, $urandom);
        run_block("t3", 7);

        // 6. Reset mid-RUN
        do_reset();
        for (int k = 0; k < 4; k++) send_word(1'b1, $urandom);
        for (int k = 0; k < 4; k++) send_word(1'b0, $urandom);
        check_launch("t6");
        for (int i = 0; i <= 10; i++) @(negedge AES_clk);
        check("t6_en_before", AES_en, 1);
        #1;
        AES_rst = 1'b1;
        #1;
        check("t6_en_async", AES_en, 0);
        check("t6_busy_async", busy, 0);
        @(negedge AES_clk);
        AES_rst = 1'b0;
        model_reset();
        @(negedge AES_clk);
        check("t6_ready", s_ready, 1);
        check("t6_key_cleared", AES_key_in, m_key_blk());
        w = $urandom;
        send_word(1'b0, w);
        for (int k = 0; k < 3; k++) send_word(1'b0, $urandom);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge AES_clk);
            if (AES_en === 1'b1) en_cnt++;
        end
        check("t6_no_launch", en_cnt, 0);
        check("t6_ready_after", s_ready, 1);
        check("t6_data_head", AES_data_in[127:96], w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
